// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: IDLE/PLAY/DYING/OVER FSM, per-frame bird physics, BCD score.
// Optional high-score register is enabled by defining FLAPPY_HISCORE_EN.
module flappy_game_ctrl #(
  parameter int BIRD_Y_INIT = 240,
  parameter int Y_MAX       = 464,
  parameter int FLAP_VEL    = 7,
  parameter int GRAVITY     = 1,
  parameter int VEL_MAX     = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        frame_tick,
  input  logic        flap_btn,
  input  logic        collide,
  input  logic        pipe_passed,
  output logic [1:0]  state,
  output logic [9:0]  bird_y,
  output logic        scroll_en,
  output logic [15:0] score_bcd,
  output logic [15:0] hiscore_bcd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic signed [5:0] LP_VEL_FLAP = 6'(-FLAP_VEL);

  state_t            r_state, w_state_nxt;
  logic [9:0]        r_bird_y, w_bird_y_nxt;
  logic signed [5:0] r_vel, w_vel_nxt;
  logic [15:0]       r_score, w_score_nxt;
  logic              r_scroll_en;
  logic              r_btn_q, r_btn_q2;
  logic              r_flap_pend, w_flap_pend_nxt;
  logic              w_flap_edge;

  // Velocity plus gravity, limited to terminal downward speed.
  function automatic logic signed [5:0] f_grav(input logic signed [5:0] v);
    logic signed [6:0] s;
    s = {v[5], v} + 7'(GRAVITY);
    return (s > $signed(7'(VEL_MAX))) ? 6'(VEL_MAX) : s[5:0];
  endfunction

  function automatic logic [9:0] f_clamp(input logic [9:0] y, input logic signed [5:0] v);
    logic [10:0] s;
    s = {1'b0, y} + {{5{v[5]}}, v};
    if (s[10])                     return 10'd0;
    else if (s[9:0] > 10'(Y_MAX))  return 10'(Y_MAX);
    else                           return s[9:0];
  endfunction

  // 4-digit BCD increment that sticks at 9999.
  function automatic logic [15:0] f_bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        c;
    r = s;
    c = 1'b1;
    if (s == 16'h9999) return s;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_flap_edge = r_btn_q & ~r_btn_q2;

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_bird_y_nxt    = r_bird_y;
    w_vel_nxt       = r_vel;
    w_score_nxt     = r_score;
    w_flap_pend_nxt = r_flap_pend | w_flap_edge;
    case (r_state)
      S_IDLE: begin
        w_bird_y_nxt = 10'(BIRD_Y_INIT);
        w_vel_nxt    = '0;
        if (w_flap_edge) begin
          w_score_nxt = '0;
          w_vel_nxt   = LP_VEL_FLAP;
          w_state_nxt = S_PLAY;
        end
      end
      S_PLAY: begin
        if (pipe_passed) w_score_nxt = f_bcd_inc(r_score);
        if (frame_tick) begin
          // An edge landing on the consuming tick only survives if an older flap was used.
          if (r_flap_pend | w_flap_edge) begin
            w_vel_nxt       = LP_VEL_FLAP;
            w_flap_pend_nxt = r_flap_pend & w_flap_edge;
          end else begin
            w_vel_nxt = f_grav(r_vel);
          end
          w_bird_y_nxt = f_clamp(r_bird_y, w_vel_nxt);
          if (collide || w_bird_y_nxt == 10'(Y_MAX)) w_state_nxt = S_DYING;
        end
      end
      S_DYING: begin
        w_flap_pend_nxt = 1'b0;
        if (frame_tick) begin
          w_vel_nxt    = f_grav(r_vel[5] ? 6'sd0 : r_vel);
          w_bird_y_nxt = f_clamp(r_bird_y, w_vel_nxt);
          if (w_bird_y_nxt == 10'(Y_MAX)) w_state_nxt = S_OVER;
        end
      end
      S_OVER: begin
        if (w_flap_edge) begin
          w_state_nxt  = S_IDLE;
          w_bird_y_nxt = 10'(BIRD_Y_INIT);
          w_vel_nxt    = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state     <= S_IDLE;
      r_bird_y    <= 10'(BIRD_Y_INIT);
      r_vel       <= '0;
      r_score     <= '0;
      r_scroll_en <= 1'b0;
      r_btn_q     <= 1'b1;
      r_btn_q2    <= 1'b1;
      r_flap_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bird_y    <= w_bird_y_nxt;
      r_vel       <= w_vel_nxt;
      r_score     <= w_score_nxt;
      r_scroll_en <= (w_state_nxt == S_PLAY);
      r_btn_q     <= flap_btn;
      r_btn_q2    <= r_btn_q;
      r_flap_pend <= w_flap_pend_nxt;
    end
  end

`ifdef FLAPPY_HISCORE_EN
  logic [15:0] r_hiscore;

  // Binary compare of valid BCD words orders them the same as an MSD-first digit compare.
  always_ff @(posedge clk) begin
    if (!clr)                                         r_hiscore <= '0;
    else if (r_state == S_OVER && r_score > r_hiscore) r_hiscore <= r_score;
  end

  assign hiscore_bcd = r_hiscore;
`else
  assign hiscore_bcd = 16'h0000;
`endif

  assign state     = r_state;
  assign bird_y    = r_bird_y;
  assign scroll_en = r_scroll_en;
  assign score_bcd = r_score;

endmodule
